// File: rtl/demux4_route_buf.sv
// Registered 1-to-4 demultiplexer: one producer word is steered by {s1,s0} into
// one of four single-entry output buffers, each with valid/ready and a delivery counter.
module demux4_route_buf #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             s1,
  input  logic             s0,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic [WIDTH-1:0] out1_data,
  output logic [WIDTH-1:0] out2_data,
  output logic [WIDTH-1:0] out3_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [CNTW-1:0]  out_count0,
  output logic [CNTW-1:0]  out_count1,
  output logic [CNTW-1:0]  out_count2,
  output logic [CNTW-1:0]  out_count3
);

  function automatic logic [CNTW-1:0] wrap_inc(input logic [CNTW-1:0] c);
    return c + {{(CNTW-1){1'b0}}, 1'b1};
  endfunction

  logic [1:0]       sel;
  logic [WIDTH-1:0] data_p0 [4];
  logic [3:0]       vld_p0;
  logic [CNTW-1:0]  cnt_p0 [4];
  logic [3:0]       acc;
  logic [3:0]       dlv;

  assign sel = {s1, s0};

  // A full slot can still take a new word in the cycle its consumer drains it.
  assign in_ready = ~reset & (~vld_p0[sel] | out_ready[sel]);
  assign dlv      = vld_p0 & out_ready;

  always_comb begin
    acc      = 4'b0000;
    acc[sel] = in_valid & in_ready;
  end

  // Stage p0: slot buffers and delivery counters
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0 <= 4'b0000;
      for (int k = 0; k < 4; k++) begin
        data_p0[k] <= '0;
        cnt_p0[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (acc[k]) data_p0[k] <= in_data;
        vld_p0[k] <= acc[k] | (vld_p0[k] & ~dlv[k]);
        if (dlv[k]) cnt_p0[k] <= wrap_inc(cnt_p0[k]);
      end
    end
  end

  assign out_valid  = vld_p0;
  assign out0_data  = data_p0[0];
  assign out1_data  = data_p0[1];
  assign out2_data  = data_p0[2];
  assign out3_data  = data_p0[3];
  assign out_count0 = cnt_p0[0];
  assign out_count1 = cnt_p0[1];
  assign out_count2 = cnt_p0[2];
  assign out_count3 = cnt_p0[3];

endmodule
